// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: bundles the fetch controller's hazard, redirect, memory and
// IF/ID signals.
//   master - the fetch controller. It receives stall/redirect/inst_in and
//            drives the memory address and IF/ID outputs.
//   slave  - the surrounding pipeline and the instruction memory.
interface fetch_ctrl_if;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] inst_in;
    logic [15:0] pc_out;
    logic        if_valid;
    logic [15:0] if_inst;
    logic [15:0] if_pc;
    logic        halted;
    logic        misalign_err;
    logic [15:0] fetch_count;

    modport master (
        input  stall, redirect, redirect_pc, inst_in,
        output pc_out, if_valid, if_inst, if_pc, halted, misalign_err, fetch_count
    );

    modport slave (
        output stall, redirect, redirect_pc, inst_in,
        input  pc_out, if_valid, if_inst, if_pc, halted, misalign_err, fetch_count
    );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch controller for the 5-stage pipeline.
// It owns the PC and drives the registered-read instruction memory address.
// It presents the fetched instruction and its PC to IF/ID, replays the
// address on stalls, and applies redirects. Fetch halts on an accepted
// all-zero instruction or on an odd redirect target.
// Ports:
//   clk - clock
//   rst - asynchronous active-low reset
//   bus - fetch_ctrl_if.master:
//         stall, redirect, redirect_pc, inst_in  in
//         pc_out, if_valid, if_inst, if_pc       out
//         halted, misalign_err, fetch_count      out
module fetch_ctrl #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int          MEM_BYTES = 64
) (
    input  logic          clk,
    input  logic          rst,
    fetch_ctrl_if.master  bus
);

    localparam logic [15:0] ADDR_MASK = 16'(MEM_BYTES - 1);

    typedef enum logic {RUN, HALT} state_t;

    state_t      state, state_nxt;
    logic [15:0] pc, pc_nxt;
    logic [15:0] last_pc, last_pc_nxt;
    logic        last_valid, last_valid_nxt;
    logic        misalign, misalign_nxt;
    logic [15:0] count, count_nxt;
    logic        accept;

    // MEM_BYTES is a power of two, so masking gives the modulo wrap.
    function automatic logic [15:0] wrap_addr(input logic [15:0] a);
        return a & ADDR_MASK;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    // A stalled or redirected cycle re-reads last_pc. This keeps if_inst
    // stable during a stall. A redirected read is discarded anyway.
    always_comb begin
        bus.pc_out = last_pc;
        if (state == RUN && !bus.stall && !bus.redirect)
            bus.pc_out = pc;
    end

    assign bus.if_valid     = last_valid && (state == RUN);
    assign bus.if_inst      = bus.inst_in;
    assign bus.if_pc        = last_pc;
    assign bus.halted       = (state == HALT);
    assign bus.misalign_err = misalign;
    assign bus.fetch_count  = count;

    assign accept = bus.if_valid && !bus.stall && !bus.redirect;

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        last_pc_nxt    = last_pc;
        last_valid_nxt = last_valid;
        misalign_nxt   = misalign;
        count_nxt      = count;
        if (state == RUN) begin
            if (bus.redirect) begin
                last_valid_nxt = 1'b0;
                if (bus.redirect_pc[0]) begin
                    state_nxt    = HALT;
                    misalign_nxt = 1'b1;
                end else begin
                    pc_nxt = wrap_addr(bus.redirect_pc);
                end
            end else if (bus.stall) begin
                // Hold everything: the memory replays last_pc.
            end else if (accept && bus.inst_in == 16'h0000) begin
                state_nxt      = HALT;
                last_valid_nxt = 1'b0;
            end else begin
                last_pc_nxt    = pc;
                last_valid_nxt = 1'b1;
                pc_nxt         = wrap_addr(pc + 16'd2);
            end
            if (accept)
                count_nxt = sat_inc(count);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= RUN;
            pc         <= RESET_PC;
            last_pc    <= RESET_PC;
            last_valid <= 1'b0;
            misalign   <= 1'b0;
            count      <= 16'd0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            last_pc    <= last_pc_nxt;
            last_valid <= last_valid_nxt;
            misalign   <= misalign_nxt;
            count      <= count_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed-vector bench for fetch_ctrl. It includes a
// byte-addressed big-endian registered-read instruction memory model.
module tb_fetch_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fetch_ctrl_if bus ();

    fetch_ctrl #(.RESET_PC(16'h0000), .MEM_BYTES(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] mem [64];
    int n_vec = 0;
    int n_bad = 0;

    // Registered read: data reflects the address sampled at the rising edge.
    always @(posedge clk) begin
        logic [5:0] a0, a1;
        a0 = bus.pc_out[5:0];
        a1 = a0 + 6'd1;
        bus.inst_in <= {mem[a0], mem[a1]};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_if(input string tag, input logic v, input logic [15:0] p, input logic [15:0] i);
        check({tag, ".valid"}, 32'(bus.if_valid), 32'(v));
        if (v) begin
            check({tag, ".pc"}, 32'(bus.if_pc), 32'(p));
            check({tag, ".inst"}, 32'(bus.if_inst), 32'(i));
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        check("rst.valid", 32'(bus.if_valid), 32'd0);
        check("rst.halted", 32'(bus.halted), 32'd0);
        check("rst.misalign", 32'(bus.misalign_err), 32'd0);
        check("rst.count", 32'(bus.fetch_count), 32'd0);
        check("rst.pc_out", 32'(bus.pc_out), 32'h0000);
        rst = 1'b1;
        // Bubble cycle before the first edge after reset.
        check("bubble.valid", 32'(bus.if_valid), 32'd0);
    endtask

    task automatic redirect_to(input logic [15:0] t);
        bus.redirect = 1'b1;
        bus.redirect_pc = t;
        step();
        bus.redirect = 1'b0;
        bus.redirect_pc = 16'h0000;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'h11;
        mem[0] = 8'hFE; mem[1] = 8'h20; mem[2] = 8'hFB;
        mem[3] = 8'h21; mem[4] = 8'h93; mem[5] = 8'hFF;
        mem[32] = 8'hF7; mem[33] = 8'hD1; mem[34] = 8'h67; mem[35] = 8'h04;
        mem[60] = 8'hFC; mem[61] = 8'hD0; mem[62] = 8'h00; mem[63] = 8'h00;
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 16'h0000;
        repeat (2) @(posedge clk);
        #1;

        // Straight-line fetch after reset.
        do_reset();
        step(); chk_if("seq0", 1'b1, 16'h0000, 16'hFE20);
        step(); chk_if("seq1", 1'b1, 16'h0002, 16'hFB21);
        step(); chk_if("seq2", 1'b1, 16'h0004, 16'h93FF);
        step(); check("seq.count", 32'(bus.fetch_count), 32'd3);

        // Stall held while 0002 sits in IF.
        do_reset();
        step(); chk_if("st0", 1'b1, 16'h0000, 16'hFE20);
        step(); chk_if("st1", 1'b1, 16'h0002, 16'hFB21);
        check("st1.count", 32'(bus.fetch_count), 32'd1);
        bus.stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(); chk_if("stall", 1'b1, 16'h0002, 16'hFB21);
            check("stall.count", 32'(bus.fetch_count), 32'd1);
        end
        bus.stall = 1'b0;
        step(); chk_if("st2", 1'b1, 16'h0004, 16'h93FF);
        check("st2.count", 32'(bus.fetch_count), 32'd2);

        // Redirect to 0020 while 0004 is in IF.
        redirect_to(16'h0020);
        check("rd.bubble", 32'(bus.if_valid), 32'd0);
        check("rd.count", 32'(bus.fetch_count), 32'd2);
        step(); chk_if("rd0", 1'b1, 16'h0020, 16'hF7D1);
        step(); chk_if("rd1", 1'b1, 16'h0022, 16'h6704);
        check("rd1.count", 32'(bus.fetch_count), 32'd3);

        // Redirect to the terminator at the top of memory.
        redirect_to(16'h003C);
        check("tm.bubble", 32'(bus.if_valid), 32'd0);
        step(); chk_if("tm0", 1'b1, 16'h003C, 16'hFCD0);
        step(); chk_if("tm1", 1'b1, 16'h003E, 16'h0000);
        check("tm1.count", 32'(bus.fetch_count), 32'd4);
        step();
        check("tm.halted", 32'(bus.halted), 32'd1);
        check("tm.valid", 32'(bus.if_valid), 32'd0);
        check("tm.count", 32'(bus.fetch_count), 32'd5);
        bus.stall = 1'b1;
        redirect_to(16'h0020);
        step();
        bus.stall = 1'b0;
        check("hold.halted", 32'(bus.halted), 32'd1);
        check("hold.valid", 32'(bus.if_valid), 32'd0);
        check("hold.count", 32'(bus.fetch_count), 32'd5);
        check("hold.pc_out", 32'(bus.pc_out), 32'h003E);
        check("hold.misalign", 32'(bus.misalign_err), 32'd0);

        // Wrap from 003E back to 0000.
        mem[62] = 8'h12; mem[63] = 8'h34;
        do_reset();
        step(); chk_if("wr0", 1'b1, 16'h0000, 16'hFE20);
        redirect_to(16'h003E);
        check("wr.bubble", 32'(bus.if_valid), 32'd0);
        step(); chk_if("wr1", 1'b1, 16'h003E, 16'h1234);
        step(); chk_if("wr2", 1'b1, 16'h0000, 16'hFE20);

        // Misaligned redirect, then asynchronous reset out of HALT.
        redirect_to(16'h0011);
        check("ma.halted", 32'(bus.halted), 32'd1);
        check("ma.err", 32'(bus.misalign_err), 32'd1);
        check("ma.valid", 32'(bus.if_valid), 32'd0);
        #2;
        do_reset();
        step(); chk_if("rs0", 1'b1, 16'h0000, 16'hFE20);
        step(); chk_if("rs1", 1'b1, 16'h0002, 16'hFB21);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
